// File: rtl/fft_peak_detector.sv
// Streaming peak finder for a serial FFT output stream. It squares each bin,
// sums the squares into |X|^2 and tracks the strongest bin of every frame.
// The pipeline has three stages: square, sum, then compare/publish.
module fft_peak_detector #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned N_BINS  = 64,
  parameter int unsigned SKIP_DC = 1,
  localparam int unsigned IDX_W  = $clog2(N_BINS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic                in_valid,
  input  logic                sync_clr,
  output logic [IDX_W-1:0]    peak_bin,
  output logic [2*DATA_W-1:0] peak_mag,
  output logic                peak_valid,
  output logic                busy
);

  localparam int unsigned MAG_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0] FIRST_IDX = (SKIP_DC != 0) ? IDX_W'(1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BINS - 1);

  logic                    accept;
  logic [IDX_W-1:0]        cnt;
  logic signed [MAG_W-1:0] re_ext, im_ext, re_prod, im_prod;
  logic                    unused_prod_msb;

  // Stage 1 registers.
  logic                    s1_valid, s1_first, s1_last, s1_skip;
  logic [MAG_W-2:0]        s1_re_sq, s1_im_sq;
  logic [IDX_W-1:0]        s1_idx;
  // Stage 2 registers.
  logic                    s2_valid, s2_first, s2_last, s2_skip;
  logic [MAG_W-1:0]        s2_mag;
  logic [IDX_W-1:0]        s2_idx;
  // Stage 3 running maximum.
  logic [MAG_W-1:0]        run_max, win_mag;
  logic [IDX_W-1:0]        run_idx, win_idx;
  logic                    upd;

  assign accept = in_valid & ~sync_clr;

  // Sign-extend before squaring. A square is never negative, so its top bit is always zero.
  always_comb begin
    re_ext  = {{DATA_W{in_data[MAG_W-1]}}, in_data[MAG_W-1:DATA_W]};
    im_ext  = {{DATA_W{in_data[DATA_W-1]}}, in_data[DATA_W-1:0]};
    re_prod = re_ext * re_ext;
    im_prod = im_ext * im_ext;
  end
  assign unused_prod_msb = re_prod[MAG_W-1] ^ im_prod[MAG_W-1];

  // Bin counter: wraps naturally because N_BINS is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (sync_clr) cnt <= '0;
    else if (accept)   cnt <= cnt + IDX_W'(1);
  end

  // Stage 1: square both components and tag the bin's role in the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_skip  <= 1'b0;
      s1_re_sq <= '0;
      s1_im_sq <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_re_sq <= re_prod[MAG_W-2:0];
        s1_im_sq <= im_prod[MAG_W-2:0];
        s1_idx   <= cnt;
        s1_first <= (cnt == FIRST_IDX);
        s1_last  <= (cnt == LAST_IDX);
        s1_skip  <= (SKIP_DC != 0) && (cnt == '0);
      end
    end
  end

  // Stage 2: |X|^2. The widened sum cannot overflow, even for two full-scale negatives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_skip  <= 1'b0;
      s2_mag   <= '0;
      s2_idx   <= '0;
    end else begin
      s2_valid <= s1_valid & ~sync_clr;
      if (s1_valid) begin
        s2_mag   <= {1'b0, s1_re_sq} + {1'b0, s1_im_sq};
        s2_idx   <= s1_idx;
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_skip  <= s1_skip;
      end
    end
  end

  // Winner including the current bin. A strict compare keeps the lowest index on ties.
  always_comb begin
    upd     = s2_valid & ~s2_skip & (s2_first | (s2_mag > run_max));
    win_mag = upd ? s2_mag : run_max;
    win_idx = upd ? s2_idx : run_idx;
  end

  // Stage 3: update the running max and publish it on the frame's last bin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_max    <= '0;
      run_idx    <= '0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
    end else if (sync_clr) begin
      run_max    <= '0;
      run_idx    <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= s2_valid & s2_last;
      if (upd) begin
        run_max <= s2_mag;
        run_idx <= s2_idx;
      end
      if (s2_valid & s2_last) begin
        peak_bin <= win_idx;
        peak_mag <= win_mag;
      end
    end
  end

  // Busy is decoded from registers only.
  assign busy = (cnt != '0) | s1_valid | s2_valid;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Bench for fft_peak_detector. Two instances (SKIP_DC = 1 and 0) receive the same stream.
// A frame-level model predicts the peaks, and a compare process checks every cycle.
module tb_fft_peak_detector;
  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        sync_clr = 1'b0;
  logic [5:0]  pb_s, pb_n;
  logic [31:0] pm_s, pm_n;
  logic        pv_s, pv_n, busy_s, busy_n;

  always #5 clk = ~clk;

  fft_peak_detector #(.DATA_W(16), .N_BINS(N), .SKIP_DC(1)) dut_s (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .sync_clr(sync_clr),
    .peak_bin(pb_s), .peak_mag(pm_s), .peak_valid(pv_s), .busy(busy_s));

  fft_peak_detector #(.DATA_W(16), .N_BINS(N), .SKIP_DC(0)) dut_n (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .sync_clr(sync_clr),
    .peak_bin(pb_n), .peak_mag(pm_n), .peak_valid(pv_n), .busy(busy_n));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state. Index 0 follows the SKIP_DC=1 instance; index 1 follows SKIP_DC=0.
  int     m_cnt;
  longint m_mag[N];
  bit     a_v, b_v, a_acc, b_acc, e_pv;
  int     a_bin[2], b_bin[2], e_bin[2];
  longint a_mag[2], b_mag[2], e_mag[2];

  // Strongest bin of the buffered frame. The first max seen wins ties.
  function automatic void peak_of(input int k, output int bin, output longint mag);
    int start;
    start = (k == 0) ? 1 : 0;
    bin = start;
    mag = m_mag[start];
    for (int b = start + 1; b < N; b++)
      if (m_mag[b] > mag) begin
        bin = b;
        mag = m_mag[b];
      end
  endfunction

  task automatic model_reset();
    m_cnt = 0; a_v = 0; b_v = 0; a_acc = 0; b_acc = 0; e_pv = 0;
    for (int k = 0; k < 2; k++) begin
      e_bin[k] = 0; e_mag[k] = 0;
    end
  endtask

  // One clock edge: a finished frame's result appears two edges after its last beat.
  task automatic model_edge(input bit v, input bit c, input logic [15:0] re,
                            input logic [15:0] im);
    longint r, i;
    if (c) begin
      m_cnt = 0; a_v = 0; b_v = 0; a_acc = 0; b_acc = 0; e_pv = 0;
      return;
    end
    e_pv = b_v;
    for (int k = 0; k < 2; k++) begin
      if (b_v) begin
        e_bin[k] = b_bin[k]; e_mag[k] = b_mag[k];
      end
      b_bin[k] = a_bin[k]; b_mag[k] = a_mag[k];
    end
    b_v = a_v; b_acc = a_acc;
    a_v = 0; a_acc = v;
    if (v) begin
      r = longint'($signed(re));
      i = longint'($signed(im));
      m_mag[m_cnt] = r * r + i * i;
      if (m_cnt == N - 1) begin
        a_v = 1;
        for (int k = 0; k < 2; k++) peak_of(k, a_bin[k], a_mag[k]);
      end
      m_cnt = (m_cnt + 1) % N;
    end
  endtask

  // Every cycle out of reset: both instances against the model.
  int cyc = 0, pulses_s = 0, last_pulse = 0, prev_pulse = 0;
  bit prev_pv = 0;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      cyc++;
      chk("pv_s", 64'(pv_s), 64'(e_pv));
      chk("pv_n", 64'(pv_n), 64'(e_pv));
      chk("bin_s", 64'(pb_s), 64'(e_bin[0]));
      chk("bin_n", 64'(pb_n), 64'(e_bin[1]));
      chk("mag_s", 64'(pm_s), 64'(e_mag[0]));
      chk("mag_n", 64'(pm_n), 64'(e_mag[1]));
      chk("busy_s", 64'(busy_s), 64'(m_cnt != 0 || a_acc || b_acc));
      chk("busy_n", 64'(busy_n), 64'(m_cnt != 0 || a_acc || b_acc));
      chk("pv_back_to_back", 64'(prev_pv & pv_s), 64'(0));
      if (pv_s === 1'b1) begin
        pulses_s++;
        prev_pulse = last_pulse;
        last_pulse = cyc;
      end
      prev_pv = (pv_s === 1'b1);
    end else begin
      prev_pv = 0;
    end
  end

  logic [15:0] f_re[N], f_im[N];

  task automatic beat(input bit v, input bit c, input logic [15:0] re, input logic [15:0] im);
    @(negedge clk);
    in_valid = v; sync_clr = c; in_data = {re, im};
    @(posedge clk);
    model_edge(v, c, re, im);
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, 16'($urandom), 16'($urandom));
  endtask

  task automatic fill(input logic [15:0] re, input logic [15:0] im);
    for (int b = 0; b < N; b++) begin
      f_re[b] = re; f_im[b] = im;
    end
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int b = 0; b < N; b++) begin
      f_re[b] = 16'(int'($urandom_range(32'(hi - lo))) + lo);
      f_im[b] = 16'(int'($urandom_range(32'(hi - lo))) + lo);
    end
  endtask

  // Send bins [0, upto) of f_re/f_im with random idle gaps.
  task automatic send(input int gap_pct, input int upto);
    for (int b = 0; b < upto; b++) begin
      while (int'($urandom_range(99)) < gap_pct) idle(1);
      beat(1'b1, 1'b0, f_re[b], f_im[b]);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_pv"}, 64'({pv_s, pv_n}), 64'(0));
    chk({tag, "_bin"}, 64'({pb_s, pb_n}), 64'(0));
    chk({tag, "_mag"}, 64'({pm_s, pm_n}), 64'(0));
    chk({tag, "_busy"}, 64'({busy_s, busy_n}), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b1;
    idle(3);

    // Single strong bin among tiny ones.
    fill(16'd1, 16'd1);
    f_re[17] = 16'd300; f_im[17] = -16'sd400;
    p0 = pulses_s;
    send(0, N);
    idle(3);
    chk("t1_model_bin", 64'(e_bin[0]), 64'(17));
    chk("t1_bin", 64'(pb_s), 64'(17));
    chk("t1_mag", 64'(pm_s), 64'(250000));
    chk("t1_pulses", 64'(pulses_s - p0), 64'(1));

    // DC exclusion: only the SKIP_DC=0 instance may report bin 0.
    fill(16'd0, 16'd0);
    f_re[0] = 16'd10000; f_re[5] = 16'd3; f_im[5] = 16'd4;
    send(0, N);
    idle(3);
    chk("dc_bin_s", 64'(pb_s), 64'(5));
    chk("dc_mag_s", 64'(pm_s), 64'(25));
    chk("dc_bin_n", 64'(pb_n), 64'(0));
    chk("dc_mag_n", 64'(pm_n), 64'(100000000));

    // Full-scale tie: the lower index wins, and the sum fits without overflow.
    fill(16'd0, 16'd0);
    f_re[9] = 16'h8000; f_im[9] = 16'h8000;
    f_re[40] = 16'h8000; f_im[40] = 16'h8000;
    send(0, N);
    idle(3);
    chk("tie_model_mag", 64'(e_mag[0]), 64'h8000_0000);
    chk("tie_bin", 64'(pb_s), 64'(9));
    chk("tie_mag", 64'(pm_s), 64'h8000_0000);

    // Back-to-back frames with no gap, then the same with random gaps.
    fill_rand(-100, 100); f_re[3] = 16'd20000; f_im[3] = -16'sd15000;
    send(0, N);
    fill_rand(-100, 100); f_re[60] = -16'sd20000; f_im[60] = 16'd15000;
    send(0, N);
    idle(3);
    chk("b2b_spacing", 64'(last_pulse - prev_pulse), 64'(N));
    chk("b2b_bin", 64'(pb_s), 64'(60));
    fill_rand(-100, 100); f_re[3] = 16'd20000;
    send(30, N);
    fill_rand(-100, 100); f_re[60] = 16'd20000;
    send(30, N);
    idle(3);
    chk("gap_bin", 64'(pb_s), 64'(60));

    // An aborted frame produces no pulse, and the outputs hold meanwhile.
    p0 = pulses_s;
    fill_rand(-50, 50); f_re[5] = 16'd30000;
    send(10, 30);
    beat(1'b1, 1'b1, 16'd32767, 16'd32767);
    fill_rand(-50, 50); f_re[12] = 16'd25000;
    send(10, N);
    idle(3);
    chk("clr_bin", 64'(pb_s), 64'(12));
    chk("clr_pulses", 64'(pulses_s - p0), 64'(1));

    // Asynchronous reset mid-frame; the next accepted beat becomes bin 0.
    fill_rand(-1000, 1000);
    send(0, 20);
    @(negedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0; sync_clr = 1'b0;
    model_reset();
    #1 chk_zero_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    fill_rand(-1000, 1000); f_im[33] = 16'd9000;
    send(20, N);
    idle(3);
    chk("after_rst_bin", 64'(pb_s), 64'(33));

    // Random frames: full-range data, tie-heavy small data and random aborts.
    for (int f = 0; f < 40; f++) begin
      if (f % 3 == 0) fill_rand(0, 2);
      else if (f % 3 == 1) fill_rand(-32768, 32767);
      else fill_rand(-300, 300);
      if ($urandom_range(5) == 0) begin
        send(int'($urandom_range(40)), int'($urandom_range(1, 62)));
        beat(1'($urandom), 1'b1, 16'($urandom), 16'($urandom));
      end else begin
        send((f % 2 == 0) ? 0 : int'($urandom_range(40)), N);
      end
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
